fpu_arbiter: RTL

- Shares one multi-cycle `fpu` instance between NUM_REQ requesters, e.g. the integer pipeline's F-extension issue slot and a debug/CSR path.
- Arbitrates round-robin and sequences the FPU protocol for each operation: `fpu_rst` pulse, then `start` held high until `done`.
- Captures `R` and returns it to the granted requester with a one-cycle pulse.
- Sits between the requesters and the `fpu` datapath; the FPU is never driven directly by the pipeline.

---
 rtl/fpu_arb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/fpu_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the FPU arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // FPU opcode encodings.
    localparam logic [1:0] FPU_OP_ADD = 2'b00;
    localparam logic [1:0] FPU_OP_MUL = 2'b01;

    // Result returned when the FPU watchdog fires.
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    // Width of the RUN-state watchdog counter.
    localparam int TMO_CNT_W = 10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit searching upward from ptr+1, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Walk the requesters in priority order starting just after the last winner.
    always_comb begin
        int   j;
        logic found;
        gnt   = '0;
        idx   = '0;
        any   = |req;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            // Guard keeps a non-power-of-two pointer from selecting past the vector.
            if (!found && (j < NUM_REQ) && req[IDX_W'(j)]) begin
                found             = 1'b1;
                gnt[IDX_W'(j)]    = 1'b1;
                idx               = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one multi-cycle FPU between NUM_REQ requesters with round-robin arbitration (optional watchdog: FPU_ARB_TIMEOUT_EN).
// Latency: gnt 1 cycle after req in IDLE; resp_valid 3 + FPU compute cycles after req is sampled.
// Backpressure: requesters hold req and operands until resp_valid; losers simply wait their turn.
module fpu_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    input  logic [2*NUM_REQ-1:0]    req_op,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [31:0]             resp_r,
    output logic                    err,
    output logic                    busy,
    output logic [31:0]             fpu_a,
    output logic [31:0]             fpu_b,
    output logic [1:0]              fpu_op,
    output logic                    fpu_rst,
    output logic                    fpu_start,
    input  logic [31:0]             fpu_r,
    input  logic                    fpu_done
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Elaboration-time sanity check on the configuration.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_cfg_check
        $error("fpu_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES 1..1023");
    end

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic [31:0]         resp_r_q, resp_r_d;
    logic [31:0]         fpu_a_q, fpu_a_d;
    logic [31:0]         fpu_b_q, fpu_b_d;
    logic [1:0]          fpu_op_q, fpu_op_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic [IDX_W-1:0]    arb_ptr;
    logic                launch;

    // In RESP the finishing owner becomes the new lowest priority, so a
    // back-to-back issue already sees the updated round-robin order.
    assign arb_ptr = (state_q == RESP) ? idx_q : ptr_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req (req),
        .ptr (arb_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

`ifdef FPU_ARB_TIMEOUT_EN
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                 err_q, err_d;
`endif

    // Next-state logic: arbitrate, sequence CLEAR/RUN/RESP, capture the result.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        idx_d        = idx_q;
        ptr_d        = ptr_q;
        resp_valid_d = '0;
        resp_r_d     = resp_r_q;
        fpu_a_d      = fpu_a_q;
        fpu_b_d      = fpu_b_q;
        fpu_op_d     = fpu_op_q;
        launch       = 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        err_d        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                launch = arb_any;
            end
            CLEAR: begin
                state_d = RUN;
`ifdef FPU_ARB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            RUN: begin
                // CLEAR already wiped any stale done, so the first RUN cycle counts.
                if (fpu_done) begin
                    resp_r_d     = fpu_r;
                    resp_valid_d = gnt_q;
                    state_d      = RESP;
                end
`ifdef FPU_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    resp_r_d     = FP_QNAN;
                    resp_valid_d = gnt_q;
                    err_d        = 1'b1;
                    state_d      = RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                ptr_d = idx_q;
                // A still-pending request issues straight away so busy never
                // drops between operations; otherwise release the FPU.
                if (arb_any) begin
                    launch = 1'b1;
                end else begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        if (launch) begin
            gnt_d    = arb_gnt;
            idx_d    = arb_idx;
            fpu_a_d  = req_a[32*arb_idx +: 32];
            fpu_b_d  = req_b[32*arb_idx +: 32];
            fpu_op_d = req_op[2*arb_idx +: 2];
            state_d  = CLEAR;
        end
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            idx_q        <= '0;
            ptr_q        <= IDX_W'(NUM_REQ - 1);
            resp_valid_q <= '0;
            resp_r_q     <= '0;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
            fpu_op_q     <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            idx_q        <= idx_d;
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_r_q     <= resp_r_d;
            fpu_a_q      <= fpu_a_d;
            fpu_b_q      <= fpu_b_d;
            fpu_op_q     <= fpu_op_d;
        end
    end

`ifdef FPU_ARB_TIMEOUT_EN
    // Watchdog counter and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign gnt        = gnt_q;
    assign resp_valid = resp_valid_q;
    assign resp_r     = resp_r_q;
    assign busy       = (state_q != IDLE);
    assign fpu_a      = fpu_a_q;
    assign fpu_b      = fpu_b_q;
    assign fpu_op     = fpu_op_q;
    assign fpu_rst    = rst | (state_q == CLEAR);
    assign fpu_start  = (state_q == RUN);

endmodule
